// File: rtl/data_mem_unit.sv
// Data-side memory stage: byte-addressable RAM, a small MMIO window (LED, cycle
// counter, status) and sticky misaligned-access capture. Loads are combinational.
module data_mem_unit #(
  parameter int          ADDR_WIDTH = 10,
  parameter logic [15:0] MMIO_TAG   = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_w,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  DMType,
  output logic [31:0] rdata,
  output logic [31:0] led_out,
  output logic        misalign_err,
  output logic [31:0] misalign_addr
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  localparam logic [2:0] DM_W  = 3'b000;
  localparam logic [2:0] DM_H  = 3'b001;
  localparam logic [2:0] DM_HU = 3'b010;
  localparam logic [2:0] DM_B  = 3'b011;
  localparam logic [2:0] DM_BU = 3'b100;

  logic [31:0] ram_q [DEPTH];

  logic [31:0] led_q, led_d;
  logic [31:0] cnt_q, cnt_d;
  logic        merr_q, merr_d;
  logic [31:0] maddr_q, maddr_d;

  logic [ADDR_WIDTH-1:0] widx;
  logic [15:0] off;
  logic        is_mmio, is_word, is_half, is_byte, type_ok, aligned, misalign;
  logic        st_ok, ram_we;
  logic [3:0]  be;
  logic [31:0] wd_lanes, mmio_word, src_word;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign widx    = addr[ADDR_WIDTH+1:2];
  assign off     = addr[15:0];
  assign is_mmio = (addr[31:16] == MMIO_TAG);

  always_comb begin
    is_word  = (DMType == DM_W);
    is_half  = (DMType == DM_H) || (DMType == DM_HU);
    is_byte  = (DMType == DM_B) || (DMType == DM_BU);
    type_ok  = is_word || is_half || is_byte;
    aligned  = is_word ? (addr[1:0] == 2'b00) : (is_half ? !addr[0] : 1'b1);
    misalign = type_ok && !aligned;
    st_ok    = mem_w && type_ok && aligned;
    ram_we   = st_ok && !is_mmio;

    be       = 4'b0000;
    wd_lanes = wdata;
    if (is_word) begin
      be = 4'b1111;
    end else if (is_half) begin
      be       = addr[1] ? 4'b1100 : 4'b0011;
      wd_lanes = {2{wdata[15:0]}};
    end else if (is_byte) begin
      be       = 4'b0001 << addr[1:0];
      wd_lanes = {4{wdata[7:0]}};
    end
  end

  // Load path: pick the source word, then apply lane extraction and extension.
  always_comb begin
    case (off)
      16'h0000: mmio_word = led_q;
      16'h0004: mmio_word = cnt_q;
      16'h0008: mmio_word = {31'b0, merr_q};
      default:  mmio_word = 32'h0;
    endcase
    src_word = is_mmio ? mmio_word : ram_q[widx];
    byte_sel = src_word[{addr[1:0], 3'b000} +: 8];
    half_sel = addr[1] ? src_word[31:16] : src_word[15:0];

    rdata = 32'h0;
    if (type_ok && aligned) begin
      case (DMType)
        DM_W:    rdata = src_word;
        DM_H:    rdata = {{16{half_sel[15]}}, half_sel};
        DM_HU:   rdata = {16'h0, half_sel};
        DM_B:    rdata = {{24{byte_sel[7]}}, byte_sel};
        DM_BU:   rdata = {24'h0, byte_sel};
        default: rdata = 32'h0;
      endcase
    end
  end

  always_comb begin
    cnt_d   = cnt_q + 32'd1;
    led_d   = led_q;
    merr_d  = merr_q;
    maddr_d = maddr_q;
    if (st_ok && is_mmio && is_word && (off == 16'h0000)) led_d = wdata;
    // Only the first fault's address is kept; the flag is sticky until reset.
    if (misalign) begin
      merr_d = 1'b1;
      if (!merr_q) maddr_d = addr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_q   <= 32'h0;
      cnt_q   <= 32'h0;
      merr_q  <= 1'b0;
      maddr_q <= 32'h0;
    end else begin
      led_q   <= led_d;
      cnt_q   <= cnt_d;
      merr_q  <= merr_d;
      maddr_q <= maddr_d;
    end
  end

  // RAM is never cleared; a store coinciding with reset at the edge is dropped.
  always_ff @(posedge clk) begin
    if (ram_we && !reset) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) ram_q[widx][8*b +: 8] <= wd_lanes[8*b +: 8];
      end
    end
  end

  assign led_out       = led_q;
  assign misalign_err  = merr_q;
  assign misalign_addr = maddr_q;

endmodule

// File: doc/data_mem_unit.md
Name: data_mem_unit

Overview:
- Data-side memory stage directly downstream of the single-cycle CPU core.
- Consumes the core's memory address, store data, memory write signal and DMType; returns load data in the same cycle.
- Contains a byte-addressable data RAM with byte/half/word access, a small memory-mapped I/O window, and sticky misaligned-access detection.

Parameters:
- ADDR_WIDTH, 10, word-index bits; RAM holds 2^ADDR_WIDTH 32-bit words.
- MMIO_TAG, 16'hFFFF, value of addr[31:16] that selects the I/O window.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- mem_w  input  1  store enable from the core.
- addr  input  32  byte address from the core's ALU.
- wdata  input  32  store data from the core.
- DMType  input  3  access type: 000 word, 001 half, 010 half-unsigned, 011 byte, 100 byte-unsigned; 101-111 invalid.
- rdata  output  32  load data to the core; combinational.
- led_out  output  32  MMIO LED register.
- misalign_err  output  1  sticky misaligned-access flag.
- misalign_addr  output  32  address of the first misaligned access.

Behaviour:
- Reset (async, immediate): led_out=0, cycle counter=0, misalign_err=0, misalign_addr=0. RAM contents are not cleared. rdata follows the combinational rules below.
- Decode:
  - addr[31:16]==MMIO_TAG selects MMIO; all other addresses select RAM.
  - RAM word index is addr[ADDR_WIDTH+1:2]. Higher address bits are ignored, so the RAM aliases.
- Alignment:
  - Word access is aligned when addr[1:0]==00.
  - Half access is aligned when addr[0]==0.
  - Byte access is always aligned.
- Loads (combinational, zero latency):
  - Little-endian.
  - Byte lane selected by addr[1:0]; half selected by addr[1].
  - Types 001 and 011 sign-extend; 010 and 100 zero-extend.
  - A misaligned load returns 0.
  - An invalid DMType returns 0.
- Stores:
  - Committed on the rising clk edge when mem_w=1, the access is aligned, and DMType is valid.
  - sb writes the lane at addr[1:0] with wdata[7:0].
  - sh writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0].
  - sw writes all four lanes.
  - Unselected lanes are unchanged.
- Read-during-write, same address: rdata shows the old value in that cycle and the new value from the next cycle.
- MMIO map (offset = addr[15:0]):
  - 0x0000, LED: read/write. Only word stores update it; byte/half stores are ignored. Loads apply the normal lane extraction to the register value.
  - 0x0004, cycle counter: read-only. Increments every clk edge after reset and wraps from FFFF_FFFF to 0. Stores are ignored.
  - 0x0008, status: read-only, value {31'b0, misalign_err}.
  - Any other offset reads 0; stores there are ignored.
  - MMIO stores never touch RAM.
- Misalignment handling:
  - A misaligned access (load, or store with mem_w=1) with a valid DMType sets misalign_err on the next clk edge.
  - misalign_addr captures addr only if misalign_err was 0 before that edge; later faults do not overwrite it.
  - Only reset clears misalign_err and misalign_addr.
  - A misaligned store is suppressed.
  - An invalid DMType never sets the flag.
- Reset asserted mid-store: the write is lost only if reset is high at the clk edge. RAM keeps all prior contents.

Test Plan:
- Word path: sw 0x12345678 @0x10, then lw @0x10 -> rdata=0x12345678; lbu @0x11 -> 0x00000056; lb @0x13 -> 0x00000012.
- Sign extension: sw 0x80FF7F80 @0x20; lb @0x20 -> 0xFFFFFF80; lbu @0x20 -> 0x00000080; lh @0x22 -> 0xFFFF80FF; lhu @0x22 -> 0x000080FF.
- Partial stores: sw 0 @0x30; sb 0xAB @0x31; sh 0xCDEF @0x32 -> lw @0x30 = 0xCDEFAB00. Also lw @(0x30 + 4·2^ADDR_WIDTH) = 0xCDEFAB00 (alias).
- Misalign: sw 0xDEADBEEF @0x41 -> RAM word 0x40 unchanged, misalign_err=1, misalign_addr=0x41. A following lh @0x43 leaves misalign_addr=0x41; status load @0xFFFF0008 -> 0x00000001.
- MMIO:
  - sw 0x000000A5 @0xFFFF0000 -> led_out=0xA5 next cycle.
  - sb 0xFF @0xFFFF0000 -> led_out stays 0xA5.
  - Two lw @0xFFFF0004 taken N cycles apart differ by N.
- Async reset: raise reset between edges -> led_out, misalign_err, misalign_addr read 0 immediately. After reset release, counter reads 0 and then counts 1, 2, …; previously written RAM data is still readable.
